// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and derived totals shared by the sync
// generator, its interface and the display pointer stage.
package vga_timing_pkg;

  localparam int POS_W   = 10;
  localparam int FRAME_W = 6;

  localparam int VGA_CLK_DIV = 4;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [POS_W-1:0]   pos_t;
  typedef logic [FRAME_W-1:0] frame_t;

  function automatic logic in_window(pos_t v, pos_t lo, pos_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster position and sync bundle from the sync generator to display stages.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  pos_t PosX;
  pos_t PosY;
  logic HSYNC;
  logic VSYNC;
  logic VideoOn;
  logic PixelTick;
  logic FrameStart;
  logic Blink;

  modport master (output PosX, PosY, HSYNC, VSYNC, VideoOn, PixelTick, FrameStart, Blink);
  modport slave  (input  PosX, PosY, HSYNC, VSYNC, VideoOn, PixelTick, FrameStart, Blink);
endinterface

// File: rtl/pixel_tick_div.sv
// Pixel clock divider: counts 0..CLK_DIV-1 and flags the last count as the
// pixel-advance strobe; the strobe is a pure decode of the counter register.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb cnt_d = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: position counters advanced by the pixel divider, plus
// registered sync/visible decode (one CLK behind position) and a frame counter.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic CLK,
  input  logic RESET,
  vga_sync_gen_if.master vga
);

  localparam pos_t H_LAST = pos_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam pos_t V_LAST = pos_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam pos_t HS_LO  = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HS_HI  = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam pos_t VS_LO  = pos_t'(V_DISPLAY + V_FRONT);
  localparam pos_t VS_HI  = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam pos_t H_VIS  = pos_t'(H_DISPLAY);
  localparam pos_t V_VIS  = pos_t'(V_DISPLAY);

  logic   tick;
  logic   x_wrap, frame_wrap;
  pos_t   x_q, x_d, y_q, y_d;
  logic   hs_q, hs_d, vs_q, vs_d, von_q, von_d, fs_q, fs_d;
  frame_t frame_q, frame_d;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .tick_o (tick)
  );

  always_comb begin
    x_wrap     = tick && (x_q == H_LAST);
    frame_wrap = x_wrap && (y_q == V_LAST);
    x_d        = x_q;
    y_d        = y_q;
    if (tick)   x_d = x_wrap ? '0 : x_q + pos_t'(1);
    if (x_wrap) y_d = (y_q == V_LAST) ? '0 : y_q + pos_t'(1);
    // Decode from the current position, so these trail the counters by one CLK.
    hs_d    = !in_window(x_q, HS_LO, HS_HI);
    vs_d    = !in_window(y_q, VS_LO, VS_HI);
    von_d   = (x_q < H_VIS) && (y_q < V_VIS);
    fs_d    = frame_wrap;
    frame_d = frame_q + frame_t'(frame_wrap);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      von_q   <= 1'b0;
      fs_q    <= 1'b0;
      frame_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      von_q   <= von_d;
      fs_q    <= fs_d;
      frame_q <= frame_d;
    end
  end

  assign vga.PosX       = x_q;
  assign vga.PosY       = y_q;
  assign vga.HSYNC      = hs_q;
  assign vga.VSYNC      = vs_q;
  assign vga.VideoOn    = von_q;
  assign vga.PixelTick  = tick;
  assign vga.FrameStart = fs_q;
  assign vga.Blink      = frame_q[FRAME_W-1];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster so 64 frames stay short; expected
// outputs come from closed-form arithmetic on the CLK count since reset release.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int D  = 4;
  localparam int HD = 8, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int LINE  = HT * D;
  localparam int FRAME = HT * VT * D;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  vga_sync_gen_if vga();

  vga_sync_gen #(
    .CLK_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .vga   (vga)
  );

  always #5 CLK = ~CLK;

  int     n_asserts = 0;
  int     n_fail    = 0;
  longint n         = 0;

  logic [25:0] obs;
  assign obs = {vga.PosX, vga.PosY, vga.HSYNC, vga.VSYNC, vga.VideoOn,
                vga.PixelTick, vga.FrameStart, vga.Blink};

  // Expected outputs after c rising edges out of reset.
  function automatic logic [25:0] model(longint c);
    longint p, q;
    logic [9:0] x, y;
    int xp, yp;
    logic hs, vs, von, tk, fs, bl;
    p  = c / D;
    x  = 10'(p % HT);
    y  = 10'((p / HT) % VT);
    tk = (c % D) == D - 1;
    if (c == 0) begin
      hs = 1'b1; vs = 1'b1; von = 1'b0; fs = 1'b0; bl = 1'b0;
    end else begin
      q   = (c - 1) / D;
      xp  = int'(q % HT);
      yp  = int'((q / HT) % VT);
      hs  = !(xp >= HD + HF && xp < HD + HF + HS);
      vs  = !(yp >= VD + VF && yp < VD + VF + VS);
      von = (xp < HD) && (yp < VD);
      fs  = (c % FRAME) == 0;
      bl  = ((c / FRAME) % 64) >= 32;
    end
    return {x, y, hs, vs, von, tk, fs, bl};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (!RESET) n++;
    check("outputs", 32'(obs), 32'(model(n)));
  endtask

  task automatic async_reset(input int hold);
    #($urandom_range(0, 3));
    RESET = 1'b1;
    #1;
    n = 0;
    check("reset_immediate", 32'(obs), 32'(model(0)));
    repeat (hold) step();
    RESET = 1'b0;
  endtask

  initial begin
    int hs_low, vs_low, vid_on, fs_cnt, first_x, first_hs, rise_n, fall_n;
    logic found, prev_blink;

    // Reset state
    RESET = 1'b1;
    repeat (3) step();
    check("rst_posx", 32'(vga.PosX), 32'd0);
    check("rst_hsync", 32'(vga.HSYNC), 32'd1);
    check("rst_videoon", 32'(vga.VideoOn), 32'd0);
    check("rst_blink", 32'(vga.Blink), 32'd0);
    RESET = 1'b0;

    // Start-up: VideoOn on edge 1, strobe every D-th cycle, PosX 1 after edge D
    for (int i = 1; i <= 3 * D; i++) begin
      step();
      if (i == 1)     check("videoon_first_edge", 32'(vga.VideoOn), 32'd1);
      if (i == D - 1) check("first_tick", 32'(vga.PixelTick), 32'd1);
      if (i == D)     check("posx_after_first_tick", 32'(vga.PosX), 32'd1);
      check("frame_start_quiet", 32'(vga.FrameStart), 32'd0);
    end

    // One line period: HSYNC low HS pixels, starting one CLK after PosX hits HD+HF
    hs_low = 0; first_x = -1; first_hs = -1;
    for (int i = 0; i < LINE; i++) begin
      step();
      if (!vga.HSYNC) hs_low++;
      if (first_x < 0 && vga.PosX == 10'(HD + HF)) first_x = int'(n);
      if (first_hs < 0 && !vga.HSYNC) first_hs = int'(n);
    end
    check("hsync_low_clks", 32'(hs_low), 32'(HS * D));
    check("hsync_lag", 32'(first_hs - first_x), 32'd1);

    // One frame period
    vs_low = 0; vid_on = 0; fs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (!vga.VSYNC) vs_low++;
      if (vga.VideoOn) vid_on++;
      if (vga.FrameStart) fs_cnt++;
    end
    check("vsync_low_clks", 32'(vs_low), 32'(VS * HT * D));
    check("videoon_clks", 32'(vid_on), 32'(HD * VD * D));
    check("frame_starts", 32'(fs_cnt), 32'd1);

    // Reset in the middle of a line in the back half of the frame
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (vga.PosX == 10'(HD + HF + 2) && vga.PosY == 10'(VD - 1)) found = 1'b1;
    end
    check("mid_frame_reached", 32'(found), 32'd1);
    async_reset(2);
    repeat (LINE + 3) step();

    // Random run lengths interrupted by random resets
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(20, 900)) step();
      async_reset($urandom_range(1, 3));
      repeat ($urandom_range(1, 2 * D)) step();
    end

    // 64 frames from a clean reset: Blink rises at frame 32 and falls at 64
    async_reset(1);
    fs_cnt = 0; rise_n = -1; fall_n = -1; prev_blink = 1'b0;
    for (int i = 0; i < 64 * FRAME; i++) begin
      step();
      if (vga.FrameStart) fs_cnt++;
      if (vga.Blink && !prev_blink) rise_n = int'(n);
      if (!vga.Blink && prev_blink) fall_n = int'(n);
      prev_blink = vga.Blink;
    end
    check("frame_starts_64", 32'(fs_cnt), 32'd64);
    check("blink_rise", 32'(rise_n), 32'(32 * FRAME));
    check("blink_fall", 32'(fall_n), 32'(64 * FRAME));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
